// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin front end that shares one registered 8-bit signed
// ALU between NUM_REQ requesters. One operation is in flight at a time:
// accept -> issue -> wait ALU_LATENCY cycles -> tagged response.
// The ALU itself lives outside this block; its active-high reset is driven
// from ~reset_in at the level above.
// Optional build macro ALU_ARB_STATS_EN adds grant_count_out, a set of
// per-requester saturating 16-bit accept counters.
module alu_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int ALU_LATENCY = 1,
    parameter int ID_W        = $clog2(NUM_REQ)
) (
    input  logic                     clock_in,
    input  logic                     reset_in,
    input  logic [NUM_REQ-1:0]       req_valid_in,
    input  logic [3*NUM_REQ-1:0]     req_opcode_in,
    input  logic [8*NUM_REQ-1:0]     req_a_in,
    input  logic [8*NUM_REQ-1:0]     req_b_in,
    output logic [NUM_REQ-1:0]       req_ready_out,
    output logic                     alu_enable_out,
    output logic [2:0]               alu_opcode_out,
    output logic signed [7:0]        alu_input1_out,
    output logic signed [7:0]        alu_input2_out,
    input  logic signed [7:0]        alu_output_in,
    output logic                     resp_valid_out,
    input  logic                     resp_ready_in,
    output logic [ID_W-1:0]          resp_id_out,
    output logic signed [7:0]        resp_data_out,
`ifdef ALU_ARB_STATS_EN
    output logic [16*NUM_REQ-1:0]    grant_count_out,
`endif
    output logic                     resp_err_out
);

    localparam int DATA_W = 8;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t                    state;
    logic [ID_W-1:0]           rr_ptr;
    logic [2:0]                wait_cnt;

    logic                      win_vld;
    logic [ID_W-1:0]           win_id;
    logic [2:0]                sel_op;
    logic signed [DATA_W-1:0]  sel_a;
    logic signed [DATA_W-1:0]  sel_b;
    logic                      accept;

    // Opcodes 5..7 have no ALU function and are answered with an error.
    function automatic logic op_supported(input logic [2:0] op);
        return (op <= 3'd4);
    endfunction

    // Round-robin search starting at rr_ptr; the lowest offset that is valid wins.
    always_comb begin
        int              sum;
        logic [ID_W-1:0] idx;
        win_vld = 1'b0;
        win_id  = '0;
        sum     = 0;
        idx     = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            sum = int'(rr_ptr) + k;
            if (sum >= NUM_REQ) begin
                sum = sum - NUM_REQ;
            end
            idx = ID_W'(sum);
            if (req_valid_in[idx]) begin
                win_vld = 1'b1;
                win_id  = idx;
            end
        end
    end

    // Route the winner's opcode and operands to the latch point.
    always_comb begin
        sel_op = '0;
        sel_a  = '0;
        sel_b  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_id == ID_W'(i)) begin
                sel_op = req_opcode_in[3*i +: 3];
                sel_a  = signed'(req_a_in[DATA_W*i +: DATA_W]);
                sel_b  = signed'(req_b_in[DATA_W*i +: DATA_W]);
            end
        end
    end

    assign accept = (state == IDLE) && win_vld;

    // One-hot ready at the winner, only while idle and out of reset.
    always_comb begin
        req_ready_out = '0;
        if (reset_in && (state == IDLE) && win_vld) begin
            req_ready_out[win_id] = 1'b1;
        end
    end

    // Sequencer: accept, issue, wait out the ALU latency, hold the response.
    always_ff @(posedge clock_in or negedge reset_in) begin
        if (!reset_in) begin
            state          <= IDLE;
            rr_ptr         <= '0;
            wait_cnt       <= '0;
            alu_enable_out <= 1'b0;
            alu_opcode_out <= '0;
            alu_input1_out <= '0;
            alu_input2_out <= '0;
            resp_valid_out <= 1'b0;
            resp_id_out    <= '0;
            resp_data_out  <= '0;
            resp_err_out   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        alu_opcode_out <= sel_op;
                        alu_input1_out <= sel_a;
                        alu_input2_out <= sel_b;
                        resp_id_out    <= win_id;
                        alu_enable_out <= op_supported(sel_op);
                        state          <= ISSUE;
                    end
                end
                ISSUE: begin
                    alu_enable_out <= 1'b0;
                    if (op_supported(alu_opcode_out)) begin
                        resp_err_out <= 1'b0;
                        wait_cnt     <= 3'(ALU_LATENCY);
                        state        <= WAIT;
                    end else begin
                        resp_err_out   <= 1'b1;
                        resp_data_out  <= '0;
                        resp_valid_out <= 1'b1;
                        state          <= RESP;
                    end
                end
                WAIT: begin
                    if (wait_cnt == 3'd1) begin
                        resp_data_out  <= alu_output_in;
                        resp_valid_out <= 1'b1;
                        wait_cnt       <= '0;
                        state          <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt - 3'd1;
                    end
                end
                RESP: begin
                    if (resp_ready_in) begin
                        resp_valid_out <= 1'b0;
                        rr_ptr         <= (resp_id_out == ID_W'(NUM_REQ - 1)) ?
                                          '0 : resp_id_out + 1'b1;
                        state          <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ALU_ARB_STATS_EN
    logic [15:0] grant_cnt [NUM_REQ];

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Per-requester accept counters, saturating, cleared only by reset.
    always_ff @(posedge clock_in or negedge reset_in) begin
        if (!reset_in) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                grant_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (accept && (win_id == ID_W'(i))) begin
                    grant_cnt[i] <= sat_inc16(grant_cnt[i]);
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt_out
        assign grant_count_out[16*g +: 16] = grant_cnt[g];
    end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed vector table plus hand-written sequences
// for round robin, back-pressure and asynchronous reset during an operation.
module tb_alu_arbiter;

    localparam int NUM_REQ     = 4;
    localparam int ALU_LATENCY = 1;
    localparam int ID_W        = 2;

    logic                     clock_in;
    logic                     reset_in;
    logic [NUM_REQ-1:0]       req_valid_in;
    logic [3*NUM_REQ-1:0]     req_opcode_in;
    logic [8*NUM_REQ-1:0]     req_a_in;
    logic [8*NUM_REQ-1:0]     req_b_in;
    logic [NUM_REQ-1:0]       req_ready_out;
    logic                     alu_enable_out;
    logic [2:0]               alu_opcode_out;
    logic signed [7:0]        alu_input1_out;
    logic signed [7:0]        alu_input2_out;
    logic signed [7:0]        alu_output_in;
    logic                     resp_valid_out;
    logic                     resp_ready_in;
    logic [ID_W-1:0]          resp_id_out;
    logic signed [7:0]        resp_data_out;
    logic                     resp_err_out;
`ifdef ALU_ARB_STATS_EN
    logic [16*NUM_REQ-1:0]    grant_count;
`endif

    alu_arbiter #(
        .NUM_REQ    (NUM_REQ),
        .ALU_LATENCY(ALU_LATENCY),
        .ID_W       (ID_W)
    ) dut (
        .clock_in      (clock_in),
        .reset_in      (reset_in),
        .req_valid_in  (req_valid_in),
        .req_opcode_in (req_opcode_in),
        .req_a_in      (req_a_in),
        .req_b_in      (req_b_in),
        .req_ready_out (req_ready_out),
        .alu_enable_out(alu_enable_out),
        .alu_opcode_out(alu_opcode_out),
        .alu_input1_out(alu_input1_out),
        .alu_input2_out(alu_input2_out),
        .alu_output_in (alu_output_in),
        .resp_valid_out(resp_valid_out),
        .resp_ready_in (resp_ready_in),
        .resp_id_out   (resp_id_out),
        .resp_data_out (resp_data_out),
`ifdef ALU_ARB_STATS_EN
        .grant_count_out(grant_count),
`endif
        .resp_err_out  (resp_err_out)
    );

    initial clock_in = 1'b0;
    always #5 clock_in = ~clock_in;

    // Behavioural ALU: 0 add, 1 sub, 2 mul, 3 eq, 4 signed gt; 8-bit result.
    function automatic logic signed [7:0] alu_f(input logic [2:0] op,
                                                input logic signed [7:0] a,
                                                input logic signed [7:0] b);
        logic signed [15:0] p;
        p = a * b;
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return p[7:0];
            3'd3:    return (a == b) ? 8'sd1 : 8'sd0;
            3'd4:    return (a > b) ? 8'sd1 : 8'sd0;
            default: return 8'sd0;
        endcase
    endfunction

    logic alu_rst;
    assign alu_rst = ~reset_in;
    logic signed [7:0] alu_pipe [ALU_LATENCY];

    always_ff @(posedge clock_in or posedge alu_rst) begin
        if (alu_rst) begin
            for (int k = 0; k < ALU_LATENCY; k++) alu_pipe[k] <= '0;
        end else begin
            if (alu_enable_out)
                alu_pipe[0] <= alu_f(alu_opcode_out, alu_input1_out, alu_input2_out);
            for (int k = 1; k < ALU_LATENCY; k++) alu_pipe[k] <= alu_pipe[k-1];
        end
    end
    assign alu_output_in = alu_pipe[ALU_LATENCY-1];

    int cyc    = 0;
    int en_cnt = 0;
    int rv_cnt = 0;
    always @(posedge clock_in) cyc <= cyc + 1;
    always @(negedge clock_in) begin
        if (alu_enable_out) en_cnt <= en_cnt + 1;
        if (resp_valid_out) rv_cnt <= rv_cnt + 1;
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock_in);
        #1;
    endtask

    task automatic set_req(input int id, input logic [2:0] op,
                           input logic [7:0] a, input logic [7:0] b);
        req_valid_in[id]          = 1'b1;
        req_opcode_in[3*id +: 3]  = op;
        req_a_in[8*id +: 8]       = a;
        req_b_in[8*id +: 8]       = b;
    endtask

    // Issue one request from a single requester and check the full transaction.
    task automatic run_op(input string nm, input int id, input logic [2:0] op,
                          input int a, input int b, input int exp_data,
                          input bit exp_err, input int exp_lat);
        int t_acc;
        int e0;
        bit got;
        e0 = en_cnt;
        req_valid_in = '0;
        set_req(id, op, 8'(a), 8'(b));
        #1;
        for (int k = 0; k < 10; k++) begin
            if (req_ready_out == NUM_REQ'(1 << id)) break;
            tick();
        end
        chk({nm, ".ready"}, int'(req_ready_out), 1 << id);
        t_acc = cyc;
        tick();
        req_valid_in  = '0;
        req_opcode_in = 12'($urandom);
        req_a_in      = $urandom;
        req_b_in      = $urandom;
        chk({nm, ".enable"}, int'(alu_enable_out), exp_err ? 0 : 1);
        got = 1'b0;
        for (int k = 0; k < 12; k++) begin
            if (resp_valid_out) begin
                got = 1'b1;
                break;
            end
            tick();
        end
        chk({nm, ".latency"}, got ? (cyc - t_acc) : -1, exp_lat);
        chk({nm, ".id"}, int'(resp_id_out), id);
        chk({nm, ".data"}, int'(resp_data_out), exp_data);
        chk({nm, ".err"}, int'(resp_err_out), int'(exp_err));
        tick();
        chk({nm, ".valid_drop"}, int'(resp_valid_out), 0);
        chk({nm, ".enable_count"}, en_cnt - e0, exp_err ? 0 : 1);
    endtask

    typedef struct {
        int         id;
        logic [2:0] op;
        int         a;
        int         b;
        int         exp_data;
        bit         exp_err;
        int         exp_lat;
    } vec_t;

    vec_t vecs [9];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int grant_id [5];
        int grant_t  [5];
        int ng;
        int bad;
        int rv0;
        bit got;

        vecs[0] = '{2, 3'd0,    5,   -3,    2, 1'b0, 3};
        vecs[1] = '{0, 3'd1,   10,   20,  -10, 1'b0, 3};
        vecs[2] = '{1, 3'd4,   -1,    1,    0, 1'b0, 3};
        vecs[3] = '{3, 3'd3, -128, -128,    1, 1'b0, 3};
        vecs[4] = '{2, 3'd2,   16,   16,    0, 1'b0, 3};
        vecs[5] = '{1, 3'd6,   33,   44,    0, 1'b1, 2};
        vecs[6] = '{0, 3'd0,  127,    1, -128, 1'b0, 3};
        vecs[7] = '{3, 3'd4,    1,   -1,    1, 1'b0, 3};
        vecs[8] = '{0, 3'd2,   -3,    5,  -15, 1'b0, 3};

        // Reset with every requester asserting: nothing may be granted.
        reset_in      = 1'b0;
        resp_ready_in = 1'b1;
        req_valid_in  = '1;
        req_opcode_in = '0;
        req_a_in      = 32'h05050505;
        req_b_in      = 32'h03030303;
        repeat (3) tick();
        chk("rst.req_ready", int'(req_ready_out), 0);
        chk("rst.alu_enable", int'(alu_enable_out), 0);
        chk("rst.alu_opcode", int'(alu_opcode_out), 0);
        chk("rst.alu_in1", int'(alu_input1_out), 0);
        chk("rst.alu_in2", int'(alu_input2_out), 0);
        chk("rst.resp_valid", int'(resp_valid_out), 0);
        chk("rst.resp_id", int'(resp_id_out), 0);
        chk("rst.resp_data", int'(resp_data_out), 0);
        chk("rst.resp_err", int'(resp_err_out), 0);
        req_valid_in = '0;
        @(negedge clock_in);
        reset_in = 1'b1;
        tick();

        // Round robin with all four requesters asserting continuously.
        for (int i = 0; i < NUM_REQ; i++) set_req(i, 3'd0, 8'(i), 8'd10);
        #1;
        ng = 0;
        for (int k = 0; k < 40 && ng < 5; k++) begin
            if (req_ready_out != '0) begin
                for (int i = 0; i < NUM_REQ; i++)
                    if (req_ready_out[i]) grant_id[ng] = i;
                grant_t[ng] = cyc;
                ng++;
            end
            tick();
        end
        req_valid_in = '0;
        chk("rr.grant_total", ng, 5);
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("rr.order%0d", k), (k < ng) ? grant_id[k] : -1, k % NUM_REQ);
            if (k > 0)
                chk($sformatf("rr.spacing%0d", k),
                    (k < ng) ? grant_t[k] - grant_t[k-1] : -1, 3 + ALU_LATENCY);
        end
        repeat (6) tick();

        // Directed vector table.
        for (int i = 0; i < 9; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].id, vecs[i].op, vecs[i].a,
                   vecs[i].b, vecs[i].exp_data, vecs[i].exp_err, vecs[i].exp_lat);
        end

        // Back-pressure: response held for 10 cycles while requester 2 waits.
        resp_ready_in = 1'b0;
        req_valid_in  = '0;
        set_req(1, 3'd0, 8'd3, 8'd4);
        #1;
        chk("bp.ready1", int'(req_ready_out), 2);
        tick();
        req_valid_in = '0;
        set_req(2, 3'd1, 8'd9, 8'd2);
        got = 1'b0;
        for (int k = 0; k < 12; k++) begin
            if (resp_valid_out) begin
                got = 1'b1;
                break;
            end
            tick();
        end
        chk("bp.resp_seen", int'(got), 1);
        bad = 0;
        for (int h = 0; h < 10; h++) begin
            if (!(resp_valid_out && resp_id_out == 2'd1 && resp_data_out == 8'sd7 &&
                  !resp_err_out && req_ready_out == '0))
                bad++;
            tick();
        end
        chk("bp.hold_bad_cycles", bad, 0);
        chk("bp.still_valid", int'(resp_valid_out), 1);
        resp_ready_in = 1'b1;
        tick();
        chk("bp.valid_drop", int'(resp_valid_out), 0);
        chk("bp.next_accept", int'(req_ready_out), 4);
        tick();
        req_valid_in = '0;
        got = 1'b0;
        for (int k = 0; k < 12; k++) begin
            if (resp_valid_out) begin
                got = 1'b1;
                break;
            end
            tick();
        end
        chk("bp.req2_seen", int'(got), 1);
        chk("bp.req2_id", int'(resp_id_out), 2);
        chk("bp.req2_data", int'(resp_data_out), 7);
        tick();

        // Asynchronous reset while the operation sits in WAIT.
        req_valid_in = '0;
        set_req(0, 3'd0, 8'd20, 8'd22);
        #1;
        chk("ar.ready0", int'(req_ready_out), 1);
        tick();
        req_valid_in = '0;
        tick();
        #2;
        reset_in     = 1'b0;
        req_valid_in = '1;
        #1;
        rv0 = rv_cnt;
        chk("ar.req_ready", int'(req_ready_out), 0);
        chk("ar.alu_enable", int'(alu_enable_out), 0);
        chk("ar.alu_opcode", int'(alu_opcode_out), 0);
        chk("ar.alu_in1", int'(alu_input1_out), 0);
        chk("ar.alu_in2", int'(alu_input2_out), 0);
        chk("ar.resp_valid", int'(resp_valid_out), 0);
        chk("ar.resp_id", int'(resp_id_out), 0);
        chk("ar.resp_data", int'(resp_data_out), 0);
        chk("ar.resp_err", int'(resp_err_out), 0);
        repeat (3) tick();
        req_valid_in = '0;
        @(negedge clock_in);
        reset_in = 1'b1;
        repeat (3) tick();
        chk("ar.no_response", rv_cnt - rv0, 0);
        set_req(1, 3'd0, 8'd1, 8'd1);
        set_req(3, 3'd0, 8'd5, 8'd6);
        #1;
        chk("ar.rr_ptr_zero", int'(req_ready_out), 2);
        run_op("ar.req3", 3, 3'd0, 5, 6, 11, 1'b0, 3);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
